fft_frame_loader: RTL and testbench
===================================

// Module: fft_frame_loader
// PURPOSE
//   Serial-to-parallel frame loader that feeds the radix-2 butterfly stage fftc0.
//   - Accepts one complex sample per cycle over a valid/ready stream.
//   - Each sample is 64 bits: {re[31:0], im[31:0]}, IEEE-754 single precision.
//   - Assembles NPOINT samples into a frame and presents the frame as the flat
//     NPOINT*DW vector that fftc0 consumes on inpmac.
//   - Ping-pong banks: the next frame loads while the current frame is held for
//     the butterfly stage.
// PARAMETERS
//   NPOINT  32  samples per frame; power of two, >= 4
//   DW      64  bits per complex sample
//   BITREV  0   1: sample k is stored at slot bitrev(k, log2(NPOINT)); 0: slot k
// PORTS
//   clk        in   1            rising-edge clock
//   reset      in   1            asynchronous, active-low reset
//   in_data    in   DW           complex sample
//   in_valid   in   1            in_data is valid this cycle
//   in_last    in   1            producer's end-of-frame marker; checked, not used to close a frame
//   in_ready   out  1            loader can accept a sample this cycle
//   out_frame  out  NPOINT*DW    frame for fftc0; slot s occupies bits [s*DW +: DW]
//   out_valid  out  1            out_frame holds a complete frame
//   out_ready  in   1            butterfly stage has taken the frame
//   wr_count   out  log2(NPOINT) index of the next sample to be written
//   err_last   out  1            sticky in_last/count mismatch flag
// BEHAVIOUR
//   State
//   - Two banks B0/B1 of NPOINT x DW registers.
//   - wr_bank, rd_bank: 1-bit pointers.
//   - full[1:0]: per-bank full flags.
//   - wr_count: write index.
//   Reset (reset=0, asynchronous)
//   - All bank bits, pointers, full, wr_count and err_last clear to 0.
//   - Outputs: out_valid=0, out_frame=0, wr_count=0, err_last=0.
//   - in_ready=1 from the first cycle after reset is released.
//   - Reset mid-frame discards partial and pending frames; no output is produced for them.
//   Write side
//   - in_ready = ~full[wr_bank]. Combinational from registers only; no path from out_ready.
//   - Accept = in_valid & in_ready. On accept:
//     - bank[wr_bank][slot] <= in_data, where slot = BITREV ? bitrev(wr_count) : wr_count;
//     - wr_count increments and wraps from NPOINT-1 to 0.
//   - Accept with wr_count==NPOINT-1 completes the frame:
//     - full[wr_bank] <= 1 and wr_bank toggles;
//     - wr_count returns to 0.
//   - in_valid without in_ready: no state change. The producer must hold the sample.
//   Read side
//   - out_valid = full[rd_bank].
//   - out_frame = bank[rd_bank], registered contents with no combinational path from in_data.
//   - Release = out_valid & out_ready. On release: full[rd_bank] <= 0 and rd_bank toggles.
//   - out_frame must stay stable while out_valid=1 and out_ready=0.
//   Latency and ordering
//   - Frame-closing accept at edge t -> out_valid=1 after edge t, if rd_bank points at that bank.
//   - Frames are delivered strictly in fill order.
//   Boundary conditions
//   - Both banks full: in_ready=0.
//   - Release and frame-closing accept in the same cycle: both take effect. The released
//     bank is writable from the next cycle.
//   - The write into a bank can never coincide with its release, because full[wr_bank]=0
//     is required to accept.
//   - out_ready while out_valid=0 is ignored.
//   err_last
//   - Set when an accepted beat has in_last != (wr_count==NPOINT-1).
//   - Clears only on reset.
//   - The frame still closes strictly on the count.
// TESTING
//   1. Reset release; stream samples k=0..31 with data {k, ~k}, BITREV=0, out_ready=1:
//      - out_valid rises 1 cycle after the sample-31 accept;
//      - slot k = {k, ~k};
//      - frame released the same cycle.
//   2. BITREV=1, same stream:
//      - slot 1 holds sample 16; slot 6 holds sample 12; slot 31 holds sample 31.
//   3. out_ready=0, stream 3 frames back-to-back:
//      - in_ready drops after the 64th accept;
//      - out_frame stays on frame 0;
//      - raise out_ready 1 cycle -> frame 1 presented and in_ready=1 on the next cycle.
//   4. Release and frame-closing accept in the same cycle:
//      - no frame lost, order preserved;
//      - in_ready stays 1.
//   5. Assert in_last on sample 20 -> err_last=1 from the next cycle; frame still closes at sample 31.
//   6. Assert reset after sample 10 of frame 1 while frame 0 is pending:
//      - out_valid=0, wr_count=0, out_frame=0 immediately;
//      - the next 32 samples form the first delivered frame.

Source files
------------

// File: rtl/fft_frame_loader.sv
// Ping-pong serial-to-parallel frame loader feeding the radix-2 butterfly stage.
// Samples stream in one per cycle; completed frames are held as a flat vector until released.
module fft_frame_loader #(
    parameter int unsigned NPOINT = 32,
    parameter int unsigned DW     = 64,
    parameter bit          BITREV = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DW-1:0]              in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [NPOINT*DW-1:0]       out_frame,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NPOINT)-1:0]  wr_count,
    output logic                       err_last
);

    localparam int unsigned AW = $clog2(NPOINT);
    localparam int unsigned FW = NPOINT * DW;

    function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] idx);
        logic [AW-1:0] rev;
        for (int i = 0; i < AW; i++) begin
            rev[i] = idx[AW-1-i];
        end
        return rev;
    endfunction

    logic [FW-1:0] r_bank [2];
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [1:0]    r_full;
    logic [AW-1:0] r_wr_count;
    logic          r_err_last;

    logic          w_accept;
    logic          w_last_beat;
    logic          w_close;
    logic          w_release;
    logic [AW-1:0] w_slot;
    logic [1:0]    w_full_nxt;

    assign w_accept    = in_valid & ~r_full[r_wr_bank];
    assign w_last_beat = (r_wr_count == AW'(NPOINT - 1));
    assign w_close     = w_accept & w_last_beat;
    assign w_release   = r_full[r_rd_bank] & out_ready;
    assign w_slot      = BITREV ? f_bitrev(r_wr_count) : r_wr_count;

    // Closing and releasing always target different banks, so both updates can apply together.
    always_comb begin
        w_full_nxt = r_full;
        if (w_close) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bank[0] <= '0;
            r_bank[1] <= '0;
        end else if (w_accept) begin
            r_bank[r_wr_bank][32'(w_slot) * DW +: DW] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_full     <= 2'b00;
            r_wr_count <= '0;
            r_err_last <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_accept) begin
                r_wr_count <= w_last_beat ? '0 : r_wr_count + AW'(1);
                if (in_last != w_last_beat) begin
                    r_err_last <= 1'b1;
                end
            end
            if (w_close) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    assign in_ready  = ~r_full[r_wr_bank];
    assign out_valid = r_full[r_rd_bank];
    assign out_frame = r_bank[r_rd_bank];
    assign wr_count  = r_wr_count;
    assign err_last  = r_err_last;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: natural-order and bit-reversed instances share one stimulus stream
// and are checked against a queue-of-frames reference model.
module tb_fft_frame_loader;

    localparam int unsigned N  = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 5;
    localparam int unsigned FW = N * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;

    logic          ir0, ir1, ov0, ov1, el0, el1;
    logic [FW-1:0] of0, of1;
    logic [AW-1:0] wc0, wc1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: completed frames in fill order, each stored with slot k = sample k.
    logic [FW-1:0] m_q[$];
    logic [FW-1:0] m_cur;
    int            m_cnt;
    bit            m_err;

    fft_frame_loader #(.NPOINT(N), .DW(DW), .BITREV(1'b0)) u_nat (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(ir0), .out_frame(of0), .out_valid(ov0), .out_ready(out_ready),
        .wr_count(wc0), .err_last(el0)
    );

    fft_frame_loader #(.NPOINT(N), .DW(DW), .BITREV(1'b1)) u_rev (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(ir1), .out_frame(of1), .out_valid(ov1), .out_ready(out_ready),
        .wr_count(wc1), .err_last(el1)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] permute(input logic [FW-1:0] f);
        logic [FW-1:0] r;
        int j;
        r = '0;
        for (int k = 0; k < N; k++) begin
            j = 0;
            for (int b = 0; b < AW; b++) j = j * 2 + ((k >> b) & 1);
            r[j*DW +: DW] = f[k*DW +: DW];
        end
        return r;
    endfunction

    function automatic int first_diff(input logic [FW-1:0] a, input logic [FW-1:0] b);
        for (int k = 0; k < N; k++) if (a[k*DW +: DW] !== b[k*DW +: DW]) return k;
        return 0;
    endfunction

    task automatic tick();
        bit acc, rel;
        acc = in_valid && (m_q.size() < 2);
        rel = out_ready && (m_q.size() > 0);
        @(posedge clk);
        if (rel) void'(m_q.pop_front());
        if (acc) begin
            if (in_last != (m_cnt == N - 1)) m_err = 1'b1;
            m_cur[m_cnt*DW +: DW] = in_data;
            if (m_cnt == N - 1) begin
                m_q.push_back(m_cur);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        #1;
    endtask

    task automatic model_clear();
        m_q.delete();
        m_cur = '0;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0;
        reset = 1'b0;
        #3;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = (m_cnt == N - 1);
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        reset = 1'b0;
        #2;
        model_clear();
        n_vec++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid got=%b/%b exp=0", ov0, ov1);
        end
        n_vec++;
        if (of0 !== '0 || of1 !== '0) begin
            n_err++; $display("FAIL reset_out_frame got_slot0=%h/%h exp=0", of0[DW-1:0], of1[DW-1:0]);
        end
        n_vec++;
        if (wc0 !== '0 || wc1 !== '0 || el0 !== 1'b0 || el1 !== 1'b0) begin
            n_err++; $display("FAIL reset_count_err got wc=%0d/%0d err=%b/%b exp=0", wc0, wc1, el0, el1);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (ir0 !== 1'b1 || ir1 !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready got=%b/%b exp=1", ir0, ir1);
        end
    endtask

    task automatic test_stream_bitrev();
        logic [DW-1:0] exp_s;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            drive_sample({32'(k), ~32'(k)});
            n_vec++;
            if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
                n_err++; $display("FAIL stream_early_valid k=%0d got=%b/%b exp=0", k, ov0, ov1);
            end
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        n_vec++;
        if (ov0 !== 1'b1 || ov1 !== 1'b1) begin
            n_err++; $display("FAIL stream_valid_rise got=%b/%b exp=1", ov0, ov1);
        end
        for (int k = 0; k < N; k++) begin
            exp_s = {32'(k), ~32'(k)};
            n_vec++;
            if (of0[k*DW +: DW] !== exp_s) begin
                n_err++; $display("FAIL stream_slot k=%0d got=%h exp=%h", k, of0[k*DW +: DW], exp_s);
            end
        end
        n_vec++;
        if (of1[1*DW +: DW] !== {32'd16, ~32'd16}) begin
            n_err++; $display("FAIL bitrev_slot1 got=%h exp=%h", of1[1*DW +: DW], {32'd16, ~32'd16});
        end
        n_vec++;
        if (of1[6*DW +: DW] !== {32'd12, ~32'd12}) begin
            n_err++; $display("FAIL bitrev_slot6 got=%h exp=%h", of1[6*DW +: DW], {32'd12, ~32'd12});
        end
        n_vec++;
        if (of1[31*DW +: DW] !== {32'd31, ~32'd31}) begin
            n_err++; $display("FAIL bitrev_slot31 got=%h exp=%h", of1[31*DW +: DW], {32'd31, ~32'd31});
        end
        n_vec++;
        if (of1 !== permute(m_q[0])) begin
            n_err++; $display("FAIL bitrev_frame slot=%0d got=%h exp=%h", first_diff(of1, permute(m_q[0])),
                of1[first_diff(of1, permute(m_q[0]))*DW +: DW], permute(m_q[0])[first_diff(of1, permute(m_q[0]))*DW +: DW]);
        end
        tick();
        n_vec++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0 || el0 !== 1'b0) begin
            n_err++; $display("FAIL stream_release got valid=%b/%b err=%b exp valid=0 err=0", ov0, ov1, el0);
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] f1;
        int accepts;
        bit exp_rdy;
        do_reset();
        out_ready = 1'b0;
        accepts = 0;
        for (int c = 0; c < 70; c++) begin
            drive_sample({$urandom, $urandom});
            exp_rdy = (m_q.size() < 2);
            n_vec++;
            if (ir0 !== exp_rdy || ir1 !== exp_rdy || (accepts < 64 && ir0 !== 1'b1)) begin
                n_err++; $display("FAIL b2b_in_ready c=%0d acc=%0d got=%b/%b exp=%b", c, accepts, ir0, ir1, exp_rdy);
            end
            if (m_q.size() > 0) begin
                n_vec++;
                if (of0 !== m_q[0]) begin
                    n_err++; $display("FAIL b2b_hold_frame0 c=%0d slot=%0d got=%h exp=%h", c, first_diff(of0, m_q[0]),
                        of0[first_diff(of0, m_q[0])*DW +: DW], m_q[0][first_diff(of0, m_q[0])*DW +: DW]);
                end
            end
            if (exp_rdy) accepts++;
            tick();
        end
        n_vec++;
        if (accepts != 64 || ir0 !== 1'b0 || ov0 !== 1'b1 || wc0 !== '0) begin
            n_err++; $display("FAIL b2b_both_full acc=%0d rdy=%b valid=%b wc=%0d exp 64/0/1/0", accepts, ir0, ov0, wc0);
        end
        f1 = m_q[1];
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (ov0 !== 1'b1 || ir0 !== 1'b1 || ir1 !== 1'b1) begin
            n_err++; $display("FAIL b2b_after_release valid=%b rdy=%b/%b exp valid=1 rdy=1", ov0, ir0, ir1);
        end
        n_vec++;
        if (of0 !== f1 || of1 !== permute(f1)) begin
            n_err++; $display("FAIL b2b_frame1 slot=%0d got=%h exp=%h", first_diff(of0, f1),
                of0[first_diff(of0, f1)*DW +: DW], f1[first_diff(of0, f1)*DW +: DW]);
        end
        for (int k = 0; k < N; k++) begin
            drive_sample({$urandom, $urandom});
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        if (ir0 !== 1'b0 || m_q.size() != 2) begin
            n_err++; $display("FAIL b2b_third_frame rdy=%b pending=%0d exp rdy=0 pending=2", ir0, m_q.size());
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (ov0 !== 1'b1 || of0 !== m_q[0] || of1 !== permute(m_q[0])) begin
            n_err++; $display("FAIL b2b_frame2 valid=%b slot=%0d got=%h exp=%h", ov0, first_diff(of0, m_q[0]),
                of0[first_diff(of0, m_q[0])*DW +: DW], m_q[0][first_diff(of0, m_q[0])*DW +: DW]);
        end
        tick();
        n_vec++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
            n_err++; $display("FAIL b2b_drained got=%b/%b exp=0", ov0, ov1);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_same_cycle();
        logic [FW-1:0] fa;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 2 * N - 1; k++) begin
            drive_sample({$urandom, $urandom});
            tick();
        end
        fa = m_q[0];
        drive_sample({$urandom, $urandom});
        out_ready = 1'b1;
        n_vec++;
        if (ov0 !== 1'b1 || of0 !== fa) begin
            n_err++; $display("FAIL same_pre valid=%b slot=%0d got=%h exp=%h", ov0, first_diff(of0, fa),
                of0[first_diff(of0, fa)*DW +: DW], fa[first_diff(of0, fa)*DW +: DW]);
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        n_vec++;
        if (ov0 !== 1'b1 || ir0 !== 1'b1 || ir1 !== 1'b1 || wc0 !== '0 || m_q.size() != 1) begin
            n_err++; $display("FAIL same_post valid=%b rdy=%b/%b wc=%0d pending=%0d exp 1/1/0/1", ov0, ir0, ir1, wc0, m_q.size());
        end
        n_vec++;
        if (of0 !== m_q[0] || of1 !== permute(m_q[0])) begin
            n_err++; $display("FAIL same_frameB slot=%0d got=%h exp=%h", first_diff(of0, m_q[0]),
                of0[first_diff(of0, m_q[0])*DW +: DW], m_q[0][first_diff(of0, m_q[0])*DW +: DW]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (ov0 !== 1'b0) begin
            n_err++; $display("FAIL same_drained got=%b exp=0", ov0);
        end
    endtask

    task automatic test_err_last();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            drive_sample({$urandom, $urandom});
            in_last = (k == 20);
            tick();
            if (k == 19) begin
                n_vec++;
                if (el0 !== 1'b0 || el1 !== 1'b0) begin
                    n_err++; $display("FAIL err_before got=%b/%b exp=0", el0, el1);
                end
            end
            if (k == 20) begin
                n_vec++;
                if (el0 !== 1'b1 || el1 !== 1'b1 || wc0 !== AW'(21)) begin
                    n_err++; $display("FAIL err_set got=%b/%b wc=%0d exp err=1 wc=21", el0, el1, wc0);
                end
            end
            if (k == 30) begin
                n_vec++;
                if (ov0 !== 1'b0) begin
                    n_err++; $display("FAIL err_early_close got=%b exp=0", ov0);
                end
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        n_vec++;
        if (ov0 !== 1'b1 || el0 !== m_err || of0 !== m_q[0]) begin
            n_err++; $display("FAIL err_close valid=%b err=%b slot=%0d got=%h exp=%h", ov0, el0, first_diff(of0, m_q[0]),
                of0[first_diff(of0, m_q[0])*DW +: DW], m_q[0][first_diff(of0, m_q[0])*DW +: DW]);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < N + 11; k++) begin
            drive_sample({$urandom, $urandom});
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        if (ov0 !== 1'b1 || wc0 !== AW'(11)) begin
            n_err++; $display("FAIL mid_setup valid=%b wc=%0d exp 1/11", ov0, wc0);
        end
        reset = 1'b0;
        #2;
        model_clear();
        n_vec++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0 || wc0 !== '0 || of0 !== '0 || of1 !== '0) begin
            n_err++; $display("FAIL mid_reset valid=%b/%b wc=%0d slot0=%h exp 0/0/0/0", ov0, ov1, wc0, of0[DW-1:0]);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            drive_sample({$urandom, $urandom});
            n_vec++;
            if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
                n_err++; $display("FAIL mid_refill k=%0d valid=%b rdy=%b exp 0/1", k, ov0, ir0);
            end
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        if (ov0 !== 1'b1 || of0 !== m_q[0] || of1 !== permute(m_q[0])) begin
            n_err++; $display("FAIL mid_first_frame valid=%b slot=%0d got=%h exp=%h", ov0, first_diff(of0, m_q[0]),
                of0[first_diff(of0, m_q[0])*DW +: DW], m_q[0][first_diff(of0, m_q[0])*DW +: DW]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (ov0 !== 1'b0) begin
            n_err++; $display("FAIL mid_no_stale got=%b exp=0", ov0);
        end
    endtask

    task automatic test_random();
        bit exp_rdy, exp_vld;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (($urandom % 4) != 0) drive_sample({$urandom, $urandom});
            else in_valid = 1'b0;
            out_ready = (c < 400) ? (($urandom % 10) < 7) : (($urandom % 10) < 3);
            exp_rdy = (m_q.size() < 2);
            exp_vld = (m_q.size() > 0);
            n_vec++;
            if (ir0 !== exp_rdy || ir1 !== exp_rdy || ov0 !== exp_vld || ov1 !== exp_vld) begin
                n_err++; $display("FAIL rnd_handshake c=%0d rdy=%b/%b valid=%b/%b exp rdy=%b valid=%b",
                    c, ir0, ir1, ov0, ov1, exp_rdy, exp_vld);
            end
            n_vec++;
            if (wc0 !== AW'(m_cnt) || wc1 !== AW'(m_cnt) || el0 !== m_err) begin
                n_err++; $display("FAIL rnd_count c=%0d wc=%0d/%0d err=%b exp wc=%0d err=%b", c, wc0, wc1, el0, m_cnt, m_err);
            end
            if (exp_vld) begin
                n_vec++;
                if (of0 !== m_q[0] || of1 !== permute(m_q[0])) begin
                    n_err++; $display("FAIL rnd_frame c=%0d slot=%0d got=%h exp=%h", c, first_diff(of0, m_q[0]),
                        of0[first_diff(of0, m_q[0])*DW +: DW], m_q[0][first_diff(of0, m_q[0])*DW +: DW]);
                end
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_stream_bitrev();
        test_back_to_back();
        test_same_cycle();
        test_err_last();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
